digit_timer_loader: RTL
=======================

// Module: digit_timer_loader
// PURPOSE
//   Front-end controller that drives the two-digit BCD countdown timer's load interface.
//   Collects a tens digit then a units digit from the keypad and validates both.
//   On Start, pulses both digit loads, gates the one-second decrement via CountEnable and
//   waits for the timer's finish flag. Sits between keypad decode and the digit timer.
// PARAMETERS
//   MAX_TENS      5   largest tens digit accepted (5 -> 00..59)
//   BLANK_CYCLES  1   RUN cycles after LOAD during which FinTIn is ignored (1..3)
// PORTS
//   clk             in   1  system clock, single domain
//   rst             in   1  synchronous reset, active-low
//   KeyValue        in   4  binary digit from keypad decoder
//   KeyValid        in   1  1-cycle strobe, KeyValue valid
//   StartKey        in   1  1-cycle strobe, start countdown
//   ClearKey        in   1  1-cycle strobe, abort/clear
//   FinTIn          in   1  finish flag from the digit timer (its FinTOut)
//   TensBinaryLoad  out  4  tens digit presented to the timer's tens load input
//   UnitsBinaryLoad out  4  units digit presented to the timer's units load input
//   TensInpLoad     out  1  tens load strobe
//   UnitsInpLoad    out  1  units load strobe
//   CountEnable     out  1  high in RUN; ANDed with the 1 s tick outside this block
//   EntryError      out  1  1-cycle pulse on rejected key or Start
//   TimerDone       out  1  1-cycle pulse when countdown completes
//   Busy            out  1  high in LOAD and RUN
// BEHAVIOUR
//   - All outputs registered. Reset (rst==0 at posedge): state IDLE, all outputs and digit regs 0.
//   - States: IDLE -> GOT_TENS -> READY -> LOAD -> RUN -> DONE -> IDLE.
//   - IDLE: KeyValid with KeyValue<=MAX_TENS -> capture into tens reg, go GOT_TENS; else EntryError.
//   - GOT_TENS: KeyValid with KeyValue<=9 -> capture units, go READY; else EntryError, stay.
//   - READY: KeyValid re-enters units digit (overwrite, same check). StartKey with digits
//     == 00 -> EntryError, stay; otherwise go LOAD. StartKey and KeyValid same cycle: Start wins.
//   - StartKey in IDLE/GOT_TENS -> EntryError, no state change.
//   - LOAD: exactly one cycle; TensInpLoad=UnitsInpLoad=1, Load buses hold captured digits
//     (buses hold digit regs in every state). Next state RUN.
//   - RUN: CountEnable=1. Blank counter loaded with BLANK_CYCLES on entry; FinTIn ignored
//     until it reaches 0. Then FinTIn==1 -> DONE. KeyValid/StartKey ignored, no EntryError.
//   - DONE: one cycle, TimerDone=1, CountEnable=0, digit regs cleared; next IDLE.
//   - ClearKey: highest priority in every state; next cycle IDLE, digits 0, strobes 0,
//     CountEnable 0, no TimerDone. Clear during LOAD suppresses nothing already issued.
//   - Latency: key accepted at edge N -> digit visible on Load bus after edge N.
//     StartKey at edge N -> load strobes high N+1..N+2, CountEnable high from N+2.
//   - EntryError never asserted in same cycle as a state change.
// STRUCTURE
//   - Shared package: state enum localparams (IDLE..DONE), BCD_MAX=9, DIGIT_W=4.
//   - Single flat module; FSM + two 4-bit digit regs + 2-bit blank counter. No sub-modules.
//   - Integration: top instantiates this with the digit timer; FinTOut -> FinTIn,
//     OneSecDec driven by (tick & CountEnable).
// TESTING
//   1 Key 3, key 7, Start -> Load buses 3/7, both strobes 1 cycle, CountEnable high,
//     FinTIn pulse after blank -> TimerDone 1 cycle, back to IDLE, Load buses 0.
//   2 Key 6 in IDLE (MAX_TENS=5) -> EntryError 1 cycle, state IDLE; key 12 as units -> EntryError.
//   3 Keys 0,0 then Start -> EntryError, no load strobes, state READY.
//   4 FinTIn held high during LOAD and first RUN cycle -> ignored; sampled after blank -> DONE.
//   5 ClearKey mid-RUN -> CountEnable 0 next cycle, IDLE, no TimerDone; rst low mid-RUN -> all 0.
//   6 READY with StartKey and KeyValid (value 4) same cycle -> LOAD with original units digit.

Source files
------------

// File: rtl/digit_timer_loader_pkg.sv
// rtl/digit_timer_loader_pkg.sv - shared types and constants for the digit timer loader
// Purpose: controller state encoding and digit width/range constants.
// Ports: none (package).
package digit_timer_loader_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GOT_TENS = 3'd1,
        READY    = 3'd2,
        LOAD     = 3'd3,
        RUN      = 3'd4,
        DONE     = 3'd5
    } loaderState_t;

endpackage

// File: rtl/digit_timer_loader.sv
// rtl/digit_timer_loader.sv - keypad entry and load/run sequencer for the BCD countdown timer
// Purpose: collects tens then units digit, validates them, loads the digit timer on Start,
//          gates the one-second decrement and reports completion.
// Ports:
//   clk, rst                        clock, synchronous active-low reset
//   KeyValue/KeyValid               keypad digit and its 1-cycle strobe
//   StartKey, ClearKey              1-cycle command strobes
//   FinTIn                          finish flag from the digit timer
//   TensBinaryLoad/UnitsBinaryLoad  captured digits, always presented to the timer
//   TensInpLoad/UnitsInpLoad        1-cycle load strobes
//   CountEnable, Busy               run gating and activity status
//   EntryError, TimerDone           1-cycle event pulses
module digit_timer_loader
    import digit_timer_loader_pkg::*;
#(
    parameter int MAX_TENS     = 5,
    parameter int BLANK_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DIGIT_W-1:0] KeyValue,
    input  logic               KeyValid,
    input  logic               StartKey,
    input  logic               ClearKey,
    input  logic               FinTIn,
    output logic [DIGIT_W-1:0] TensBinaryLoad,
    output logic [DIGIT_W-1:0] UnitsBinaryLoad,
    output logic               TensInpLoad,
    output logic               UnitsInpLoad,
    output logic               CountEnable,
    output logic               EntryError,
    output logic               TimerDone,
    output logic               Busy
);

    localparam logic [DIGIT_W-1:0] maxTens   = DIGIT_W'(MAX_TENS);
    localparam logic [1:0]         blankInit = 2'(BLANK_CYCLES);

    loaderState_t state;
    logic [1:0]   blankCnt;

    // The digit registers are the load buses themselves, so a captured digit is
    // visible to the timer immediately after the accepting edge.
    // Status/strobe outputs are registered from the current state, so they trail
    // the state by one cycle: Start at edge N gives strobes over N+1..N+2 and
    // CountEnable from N+2.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= IDLE;
            blankCnt        <= '0;
            TensBinaryLoad  <= '0;
            UnitsBinaryLoad <= '0;
            TensInpLoad     <= 1'b0;
            UnitsInpLoad    <= 1'b0;
            CountEnable     <= 1'b0;
            EntryError      <= 1'b0;
            TimerDone       <= 1'b0;
            Busy            <= 1'b0;
        end else begin
            EntryError   <= 1'b0;
            TensInpLoad  <= (state == LOAD);
            UnitsInpLoad <= (state == LOAD);
            CountEnable  <= (state == RUN);
            Busy         <= (state == LOAD) || (state == RUN);
            TimerDone    <= (state == DONE);

            if (ClearKey) begin
                // Abort wins over everything, including a pending strobe or finish.
                state           <= IDLE;
                blankCnt        <= '0;
                TensBinaryLoad  <= '0;
                UnitsBinaryLoad <= '0;
                TensInpLoad     <= 1'b0;
                UnitsInpLoad    <= 1'b0;
                CountEnable     <= 1'b0;
                TimerDone       <= 1'b0;
                Busy            <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (StartKey) begin
                            EntryError <= 1'b1;
                        end else if (KeyValid) begin
                            if (KeyValue <= maxTens) begin
                                TensBinaryLoad <= KeyValue;
                                state          <= GOT_TENS;
                            end else begin
                                EntryError <= 1'b1;
                            end
                        end
                    end
                    GOT_TENS, READY: begin
                        if (StartKey) begin
                            // Start takes precedence over a simultaneous key.
                            if (state == READY &&
                                {TensBinaryLoad, UnitsBinaryLoad} != '0) begin
                                state <= LOAD;
                            end else begin
                                EntryError <= 1'b1;
                            end
                        end else if (KeyValid) begin
                            if (KeyValue <= BCD_MAX) begin
                                UnitsBinaryLoad <= KeyValue;
                                state           <= READY;
                            end else begin
                                EntryError <= 1'b1;
                            end
                        end
                    end
                    LOAD: begin
                        blankCnt <= blankInit;
                        state    <= RUN;
                    end
                    RUN: begin
                        // A stale finish flag from the previous count is masked
                        // until the timer has had time to take the new load.
                        if (blankCnt != 2'd0) begin
                            blankCnt <= blankCnt - 2'd1;
                        end else if (FinTIn) begin
                            state <= DONE;
                        end
                    end
                    DONE: begin
                        TensBinaryLoad  <= '0;
                        UnitsBinaryLoad <= '0;
                        state           <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
